// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare counters plus direct-mapped BTB next-PC predictor with decode-stage check
module branch_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int HIST_WIDTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic [31:0] pc_f_i,
  output logic        predict_taken_f_o,
  output logic [31:0] predict_pc_f_o,
  input  logic        branch_d_i,
  input  logic        taken_d_i,
  input  logic [31:0] target_d_i,
  output logic        predict_miss_o,
  output logic [31:0] recover_pc_o
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = 30 - INDEX_WIDTH;

  logic [1:0]             cnt        [ENTRIES];
  logic                   btb_valid  [ENTRIES];
  logic [TAG_W-1:0]       btb_tag    [ENTRIES];
  logic [31:0]            btb_target [ENTRIES];
  logic [HIST_WIDTH-1:0]  ghr;
  logic [HIST_WIDTH-1:0]  ghr_next;

  logic [31:0]            pc_d;
  logic                   pred_taken_d;
  logic [31:0]            pred_target_d;
  logic [INDEX_WIDTH-1:0] cidx_d;

  logic [INDEX_WIDTH-1:0] bidx;
  logic [INDEX_WIDTH-1:0] cidx;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_W-1:0]       tag_f;
  logic [TAG_W-1:0]       tag_d;
  logic                   hit;
  logic                   update;
  logic                   alias_kill;

  // The hazard unit stalls fetch and decode together, so the decode stall alone governs state.
  logic unused_stall_f;
  assign unused_stall_f = stall_f_i;

  assign bidx  = pc_f_i[INDEX_WIDTH+1:2];
  assign tag_f = pc_f_i[31:INDEX_WIDTH+2];
  assign cidx  = bidx ^ INDEX_WIDTH'(ghr);
  assign hit   = btb_valid[bidx] && (btb_tag[bidx] == tag_f);

  assign predict_taken_f_o = hit && cnt[cidx][1];
  assign predict_pc_f_o    = predict_taken_f_o ? btb_target[bidx] : pc_f_i + 32'd4;

  assign upd_idx    = pc_d[INDEX_WIDTH+1:2];
  assign tag_d      = pc_d[31:INDEX_WIDTH+2];
  assign update     = branch_d_i && !stall_d_i;
  // A taken prediction on a non-branch means a stale BTB alias; drop that entry.
  assign alias_kill = !branch_d_i && pred_taken_d && !stall_d_i;

  generate
    if (HIST_WIDTH == 1) begin : g_hist1
      assign ghr_next = taken_d_i;
    end else begin : g_histn
      assign ghr_next = {ghr[HIST_WIDTH-2:0], taken_d_i};
    end
  endgenerate

  // Compare the carried prediction with the resolved outcome and pick the recovery PC.
  always_comb begin
    predict_miss_o = pred_taken_d;
    if (branch_d_i) begin
      predict_miss_o = (taken_d_i != pred_taken_d) ||
                       (taken_d_i && (target_d_i != pred_target_d));
    end
    recover_pc_o = (branch_d_i && taken_d_i) ? target_d_i : pc_d + 32'd4;
  end

  // Decode-stage copy of the fetch prediction; stall holds, flush clears.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_d          <= '0;
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
      cidx_d        <= '0;
    end else if (stall_d_i) begin
      pc_d          <= pc_d;
    end else if (flush_d_i) begin
      pc_d          <= '0;
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
      cidx_d        <= '0;
    end else begin
      pc_d          <= pc_f_i;
      pred_taken_d  <= predict_taken_f_o;
      pred_target_d <= predict_pc_f_o;
      cidx_d        <= cidx;
    end
  end

  // Train the saturating counter used by this branch and shift the outcome into history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b01;
      ghr <= '0;
    end else if (update) begin
      ghr <= ghr_next;
      if (taken_d_i && (cnt[cidx_d] != 2'b11)) begin
        cnt[cidx_d] <= cnt[cidx_d] + 2'b01;
      end else if (!taken_d_i && (cnt[cidx_d] != 2'b00)) begin
        cnt[cidx_d] <= cnt[cidx_d] - 2'b01;
      end
    end
  end

  // Install taken targets in the BTB; invalidate entries that aliased onto non-branches.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (update && taken_d_i) begin
      btb_valid[upd_idx]  <= 1'b1;
      btb_tag[upd_idx]    <= tag_d;
      btb_target[upd_idx] <= target_d_i;
    end else if (alias_kill) begin
      btb_valid[upd_idx]  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor with directed vectors
module tb_branch_predictor;

  typedef struct packed {
    int          id;
    logic        cf;
    logic        ptf;
    logic [31:0] ppc;
    logic        cd;
    logic        miss;
    logic [31:0] rec;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] pc_f;
  logic        ptf;
  logic [31:0] ppc;
  logic        branch_d;
  logic        taken_d;
  logic [31:0] target_d;
  logic        miss;
  logic [31:0] rec;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  branch_predictor #(.INDEX_WIDTH(6), .HIST_WIDTH(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .stall_f_i(stall_f),
    .stall_d_i(stall_d),
    .flush_d_i(flush_d),
    .pc_f_i(pc_f),
    .predict_taken_f_o(ptf),
    .predict_pc_f_o(ppc),
    .branch_d_i(branch_d),
    .taken_d_i(taken_d),
    .target_d_i(target_d),
    .predict_miss_o(miss),
    .recover_pc_o(rec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, pop one expectation and compare.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      if (m.cf) begin
        checks++;
        if (ptf !== m.ptf) begin
          errors++;
          $display("FAIL ptf#%0d got %0b want %0b", m.id, ptf, m.ptf);
        end
        checks++;
        if (ppc !== m.ppc) begin
          errors++;
          $display("FAIL ppc#%0d got %h want %h", m.id, ppc, m.ppc);
        end
      end
      if (m.cd) begin
        checks++;
        if (miss !== m.miss) begin
          errors++;
          $display("FAIL miss#%0d got %0b want %0b", m.id, miss, m.miss);
        end
        checks++;
        if (rec !== m.rec) begin
          errors++;
          $display("FAIL rec#%0d got %h want %h", m.id, rec, m.rec);
        end
      end
    end
  end

  // One pipeline cycle: drive fetch and decode inputs, queue what must appear, advance.
  task automatic cyc(input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic stl, input logic fl,
                     input logic cf, input logic eptf, input logic [31:0] eppc,
                     input logic cd, input logic emiss, input logic [31:0] erec);
    exp_t e;
    pc_f     = pc;
    branch_d = br;
    taken_d  = tk;
    target_d = tgt;
    stall_d  = stl;
    stall_f  = stl;
    flush_d  = fl;
    if (cf || cd) begin
      e.id   = next_id;
      e.cf   = cf;
      e.ptf  = eptf;
      e.ppc  = eppc;
      e.cd   = cd;
      e.miss = emiss;
      e.rec  = erec;
      sb.push_back(e);
      next_id++;
    end
    @(posedge clk);
    #1;
  endtask

  // Fetch 0x40 (decode holds the 0x140 filler), then resolve it in decode.
  task automatic iter(input logic tk, input logic br, input int stl,
                      input logic eptf, input logic emiss);
    logic [31:0] erec;
    erec = (br && tk) ? 32'h80 : 32'h44;
    cyc(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
        1'b1, eptf, eptf ? 32'h80 : 32'h44, 1'b1, 1'b0, 32'h144);
    for (int s = 0; s < stl; s++) begin
      cyc(32'h140, br, tk, 32'h80, 1'b1, 1'b0,
          1'b1, 1'b0, 32'h144, 1'b1, emiss, erec);
    end
    cyc(32'h140, br, tk, 32'h80, 1'b0, 1'b0,
        1'b1, 1'b0, 32'h144, 1'b1, emiss, erec);
  endtask

  initial begin
    rst_n    = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    pc_f     = 32'h0;
    branch_d = 1'b0;
    taken_d  = 1'b0;
    target_d = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state: cold taken branch in decode (stalled, no training), then idle decode.
    cyc(32'h140, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h144, 1'b1, 1'b1, 32'h300);
    cyc(32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h144, 1'b1, 1'b0, 32'h4);

    // History training: counters 16,17,19,23,31 miss, the sixth hits.
    for (int i = 0; i < 5; i++) iter(1'b1, 1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) iter(1'b1, 1'b1, 0, 1'b1, 1'b0);
    // Saturated counter 31 steps down to 10 on a not-taken outcome.
    iter(1'b0, 1'b1, 0, 1'b1, 1'b1);
    // Walk history back to 1111 through counters 30,29,27,23 then confirm 31 still predicts taken.
    for (int i = 0; i < 3; i++) iter(1'b1, 1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) iter(1'b1, 1'b1, 0, 1'b1, 1'b0);
    // Stalled misprediction held three cycles; a single update leaves counter 31 at 10.
    iter(1'b0, 1'b1, 3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) iter(1'b1, 1'b1, 0, 1'b1, 1'b0);

    // Flush while a taken prediction is in fetch; decode then carries no prediction.
    cyc(32'h40,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80,  1'b1, 1'b0, 32'h144);
    cyc(32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h144, 1'b1, 1'b0, 32'h4);

    // Non-branch alias misses and drops the BTB entry; retrain restores it.
    iter(1'b0, 1'b0, 0, 1'b1, 1'b1);
    iter(1'b1, 1'b1, 0, 1'b0, 1'b1);
    iter(1'b1, 1'b1, 0, 1'b1, 1'b0);

    // Mid-run reset wipes the trained entry.
    rst_n = 1'b0;
    cyc(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    cyc(32'h40,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h44,  1'b1, 1'b0, 32'h4);
    cyc(32'h140, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h144, 1'b1, 1'b0, 32'h44);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached want finish");
    $fatal(1);
  end

endmodule
